// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the hazard scoreboard slice.
//   - Stage encodings used on the forwarding-select outputs
//     (REG = regfile, E, M, W).
//   - Width of the tnew/tuse timing fields.
//   - The record stored for each in-flight instruction (one per stage E..W).
//   - A small saturating-decrement helper for tnew.
package hazard_pkg;

  localparam int STAGE_REG = 0;
  localparam int STAGE_E   = 1;
  localparam int STAGE_M   = 2;
  localparam int STAGE_W   = 3;

  localparam int TW = 2;

  // Upper bound on the number of source operands a stage record can carry.
  localparam int SRC_MAX = 4;

  typedef logic [TW-1:0] timing_t;
  typedef logic [4:0]    regNum_t;

  typedef struct packed {
    logic                       valid;
    logic                       we;
    regNum_t                    dst;
    timing_t                    tnew;
    regNum_t [SRC_MAX-1:0]      src;
    logic    [SRC_MAX-1:0]      srcUsed;
    logic                       mdStart;
    logic                       mdDiv;
  } entry_t;

  // Result readiness counts down once per stage advance and sticks at zero.
  function automatic timing_t decSat(input timing_t t);
    return (t == '0) ? '0 : timing_t'(t - 1'b1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match
//   Youngest-producer selection for one consumer operand.
//   Scans the in-flight stages strictly older than the consumer stage and
//   picks the youngest one that writes the consumer's register. Register 0
//   never matches.
// Parameters
//   NST      pipeline depth from D through W
//   CONSUMER stage index of the consumer (0 = D, 1 = E)
// Ports
//   src        register number read by the consumer
//   prodValid  per-stage valid bit (stages 1..NST-1)
//   prodWe     per-stage write-enable
//   prodDst    per-stage destination register
//   prodTnew   per-stage remaining cycles until the result is forwardable
//   stage      matched stage index, 0 when no producer matches
//   tnew       tnew of the matched producer, 0 when no producer matches
module hazard_match
  import hazard_pkg::*;
#(
  parameter  int NST      = 4,
  parameter  int CONSUMER = 0,
  localparam int SW       = $clog2(NST)
) (
  input  regNum_t              src,
  input  logic    [NST-1:1]    prodValid,
  input  logic    [NST-1:1]    prodWe,
  input  regNum_t [NST-1:1]    prodDst,
  input  timing_t [NST-1:1]    prodTnew,
  output logic    [SW-1:0]     stage,
  output timing_t              tnew
);

  // Walk from the oldest stage towards the youngest so that the last hit
  // written (the smallest stage index above the consumer) wins. Only the
  // youngest writer carries the architecturally current value, so older
  // copies are deliberately ignored even if they are already ready.
  always_comb begin
    stage = '0;
    tnew  = '0;
    for (int p = NST-1; p >= 1; p--) begin
      if ((p > CONSUMER) && prodValid[p] && prodWe[p] &&
          (prodDst[p] != '0) && (prodDst[p] == src)) begin
        stage = SW'(p);
        tnew  = prodTnew[p];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks instructions in stages E..W, produces forwarding selects for the
//   D and E consumers, and raises a stall for RAW hazards the forwarding
//   network cannot cover yet and for mult/div unit conflicts.
// Parameters
//   NSRC      source operands per instruction
//   NST       pipeline depth from D through W
//   MULT_CYC  mult busy cycles
//   DIV_CYC   div busy cycles
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   d_valid                  D-stage instruction valid
//   d_src / d_src_used       D source registers and their read flags
//   d_tuse                   per source: cycles after D until consumed
//   d_we / d_dst / d_tnew    D destination write info and result latency
//   d_md_use / d_md_start / d_md_div   mult/div usage of the D instruction
//   stall                    freeze PC/F/D, bubble into E
//   fwd_sel_d / fwd_sel_e    per source forwarding stage (0 = regfile)
//   md_busy                  mult/div unit busy
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NSRC     = 2,
  parameter  int NST      = 4,
  parameter  int MULT_CYC = 5,
  parameter  int DIV_CYC  = 10,
  localparam int SW       = $clog2(NST)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 d_valid,
  input  logic [NSRC*5-1:0]    d_src,
  input  logic [NSRC-1:0]      d_src_used,
  input  logic [NSRC*TW-1:0]   d_tuse,
  input  logic                 d_we,
  input  logic [4:0]           d_dst,
  input  logic [TW-1:0]        d_tnew,
  input  logic                 d_md_use,
  input  logic                 d_md_start,
  input  logic                 d_md_div,
  output logic                 stall,
  output logic [NSRC*SW-1:0]   fwd_sel_d,
  output logic [NSRC*SW-1:0]   fwd_sel_e,
  output logic                 md_busy
);

  localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int MDW    = $clog2(MD_MAX + 1);

  entry_t               entryQ [1:NST-1];
  entry_t               dEntry;
  logic    [NST-1:1]    prodValid;
  logic    [NST-1:1]    prodWe;
  regNum_t [NST-1:1]    prodDst;
  timing_t [NST-1:1]    prodTnew;
  timing_t [NSRC-1:0]   tnewD;
  timing_t [NSRC-1:0]   unusedTnewE;
  logic                 rawStall;
  logic    [MDW-1:0]    mdCount;
  logic                 unusedEntryBits;

  // Build the record that enters E. A stalled or invalid D slot becomes an
  // all-zero bubble, so stale register numbers never linger in E.
  always_comb begin
    dEntry = '0;
    if (d_valid && !stall) begin
      dEntry.valid   = 1'b1;
      dEntry.we      = d_we;
      dEntry.dst     = d_dst;
      dEntry.tnew    = d_tnew;
      dEntry.mdStart = d_md_start;
      dEntry.mdDiv   = d_md_div;
      for (int k = 0; k < NSRC; k++) begin
        dEntry.src[k]     = d_src[k*5 +: 5];
        dEntry.srcUsed[k] = d_src_used[k];
      end
    end
  end

  // Stage records shift one place every cycle. A stall only affects what
  // enters E (the bubble above); older instructions keep draining, and their
  // tnew counts down on each move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 1; p < NST; p++) begin
        entryQ[p] <= '0;
      end
    end else begin
      entryQ[1] <= dEntry;
      for (int p = 2; p < NST; p++) begin
        entryQ[p]      <= entryQ[p-1];
        entryQ[p].tnew <= decSat(entryQ[p-1].tnew);
      end
    end
  end

  // Flatten the producer-side fields so each matcher sees plain vectors.
  always_comb begin
    prodValid = '0;
    prodWe    = '0;
    prodDst   = '0;
    prodTnew  = '0;
    for (int p = 1; p < NST; p++) begin
      prodValid[p] = entryQ[p].valid;
      prodWe[p]    = entryQ[p].we;
      prodDst[p]   = entryQ[p].dst;
      prodTnew[p]  = entryQ[p].tnew;
    end
  end

  // One matcher per operand for the D consumer and one for the E consumer.
  // The E matchers read the register numbers latched with the instruction.
  for (genvar k = 0; k < NSRC; k++) begin : gSrc
    hazard_match #(
      .NST      (NST),
      .CONSUMER (STAGE_REG)
    ) uMatchD (
      .src       (d_src[k*5 +: 5]),
      .prodValid (prodValid),
      .prodWe    (prodWe),
      .prodDst   (prodDst),
      .prodTnew  (prodTnew),
      .stage     (fwd_sel_d[k*SW +: SW]),
      .tnew      (tnewD[k])
    );

    hazard_match #(
      .NST      (NST),
      .CONSUMER (STAGE_E)
    ) uMatchE (
      .src       (entryQ[1].src[k]),
      .prodValid (prodValid),
      .prodWe    (prodWe),
      .prodDst   (prodDst),
      .prodTnew  (prodTnew),
      .stage     (fwd_sel_e[k*SW +: SW]),
      .tnew      (unusedTnewE[k])
    );
  end

  // RAW hazard: an operand that is really read needs its youngest producer
  // to be ready no later than the cycle the operand is consumed.
  always_comb begin
    rawStall = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (d_src_used[k] && (fwd_sel_d[k*SW +: SW] != '0) &&
          (tnewD[k] > d_tuse[k*TW +: TW])) begin
        rawStall = 1'b1;
      end
    end
  end

  // Mult/div busy counter. It is loaded the cycle after a start sits in E
  // and then counts down; while the start itself is in E the unit already
  // reports busy through md_busy below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdCount <= '0;
    end else if (entryQ[1].valid && entryQ[1].mdStart) begin
      mdCount <= entryQ[1].mdDiv ? MDW'(DIV_CYC) : MDW'(MULT_CYC);
    end else if (mdCount != '0) begin
      mdCount <= mdCount - 1'b1;
    end
  end

  assign md_busy = (mdCount != '0) | (entryQ[1].valid & entryQ[1].mdStart);
  assign stall   = d_valid & (rawStall | (d_md_use & md_busy));

  // Not every stored field is consumed in every stage; fold them into a
  // dummy so the full record can stay uniform across stages.
  always_comb begin
    unusedEntryBits = 1'b0;
    for (int p = 1; p < NST; p++) begin
      unusedEntryBits = unusedEntryBits ^ (^entryQ[p]);
    end
  end

endmodule
